// File: rtl/aes_pkg.sv
// ============================================================================
//  aes_pkg
//  Shared widths, block/entry types and packer state encoding for the AES
//  front end, plus a byte-slot insertion helper.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int BLOCK_W     = 128;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_BYTES = 16;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef struct packed {
        block_t data;
        logic   encrypt;
    } blk_entry_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PAD  = 1'b1
    } packer_state_t;

    // Returns blk with byte b written into byte slot 'slot'; slot 0 is the
    // top byte when msb_first is set, otherwise the bottom byte.
    function automatic block_t put_byte(input block_t blk, input logic [3:0] slot,
                                        input logic [BYTE_W-1:0] b, input logic msb_first);
        block_t r;
        r = blk;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (slot == 4'(i)) begin
                if (msb_first) r[BLOCK_W-1-BYTE_W*i -: BYTE_W] = b;
                else           r[BYTE_W*i +: BYTE_W]           = b;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/block_fifo.sv
// ============================================================================
//  block_fifo
//  Synchronous FIFO of blk_entry_t with registered head outputs and an exact
//  occupancy count. A push into an empty FIFO is visible after that edge.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module block_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  blk_entry_t               push_data,
    input  logic                     pop,
    output blk_entry_t               head,
    output logic                     head_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_full_count = (PTR_W+1)'(DEPTH);

    blk_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    blk_entry_t       r_head;
    logic             r_head_valid;

    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_rd_next;
    logic [PTR_W:0]   w_count_next;
    blk_entry_t       w_head_next;

    assign w_pop     = pop && (r_count != '0);
    assign w_push    = push && ((r_count != c_full_count) || w_pop);
    assign w_rd_next = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (PTR_W+1)'(1);
            2'b01:   w_count_next = r_count - (PTR_W+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // The new head is the entry being written this edge whenever the write
    // slot coincides with the post-pop read slot.
    assign w_head_next = (w_push && (r_wr_ptr == w_rd_next)) ? push_data : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head       <= '0;
            r_head_valid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rd_ptr     <= w_rd_next;
            r_count      <= w_count_next;
            r_head       <= w_head_next;
            r_head_valid <= (w_count_next != '0);
        end
    end

    assign head       = r_head;
    assign head_valid = r_head_valid;
    assign full       = (r_count == c_full_count);
    assign count      = r_count;

endmodule

`default_nettype wire

// File: rtl/rx_block_packer.sv
// ============================================================================
//  rx_block_packer
//  Packs an RX byte stream into 128-bit blocks with a per-block mode bit and
//  buffers them for the cipher. RX_PKCS7_PAD_EN pads partial blocks instead
//  of dropping them.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rx_block_packer
    import aes_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    input  logic                          in_encrypt,
    output logic [127:0]                  out_block,
    output logic                          out_encrypt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          drop_pulse
);

    logic [3:0]  r_cnt;
    block_t      r_fill;
    logic        r_mode;

    logic        w_fifo_full;
    logic        w_accept;
    logic        w_cnt_last;
    logic        w_write;
    logic        w_push;
    logic [7:0]  w_byte;
    logic [3:0]  w_cnt_inc;
    block_t      w_fill_next;
    blk_entry_t  w_push_entry;
    blk_entry_t  w_head;

`ifdef RX_PKCS7_PAD_EN
    localparam logic [0:0] c_st_fill = 1'(FILL);
    localparam logic [0:0] c_st_pad  = 1'(PAD);

    logic [0:0]  r_state;
    logic [7:0]  r_pad;
    logic        w_in_pad;
    logic [4:0]  w_pad_len;

    assign w_in_pad  = (r_state == c_st_pad);
    assign w_byte    = w_in_pad ? r_pad : in_data;
    // Pad bytes advance every cycle; only the final, block-completing one waits on space.
    assign w_write   = w_accept || (w_in_pad && !(w_cnt_last && w_fifo_full));
    assign w_pad_len = 5'd16 - {1'b0, w_cnt_inc};
    assign in_ready  = !rst && (r_state == c_st_fill) && !(w_cnt_last && w_fifo_full);
    assign drop_pulse = 1'b0;
`else
    logic        r_drop;

    assign w_byte     = in_data;
    assign w_write    = w_accept;
    assign in_ready   = !rst && !(w_cnt_last && w_fifo_full);
    assign drop_pulse = r_drop;
`endif

    assign w_accept     = in_valid && in_ready;
    assign w_cnt_last   = (r_cnt == 4'd15);
    assign w_cnt_inc    = r_cnt + 4'd1;
    assign w_push       = w_write && w_cnt_last;
    assign w_fill_next  = put_byte(r_fill, r_cnt, w_byte, MSB_FIRST != 0);
    assign w_push_entry = '{data: w_fill_next, encrypt: r_mode};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_fill  <= '0;
            r_mode  <= 1'b0;
`ifdef RX_PKCS7_PAD_EN
            r_state <= c_st_fill;
            r_pad   <= 8'd0;
`else
            r_drop  <= 1'b0;
`endif
        end else begin
`ifndef RX_PKCS7_PAD_EN
            r_drop <= 1'b0;
`endif
            if (w_accept && (r_cnt == 4'd0)) r_mode <= in_encrypt;
            if (w_write) begin
                if (w_cnt_last) begin
                    r_cnt   <= 4'd0;
                    r_fill  <= '0;
`ifdef RX_PKCS7_PAD_EN
                    r_state <= c_st_fill;
`endif
                end else if (w_accept && in_last) begin
`ifdef RX_PKCS7_PAD_EN
                    r_cnt   <= w_cnt_inc;
                    r_fill  <= w_fill_next;
                    r_state <= c_st_pad;
                    r_pad   <= {3'b000, w_pad_len};
`else
                    r_cnt   <= 4'd0;
                    r_fill  <= '0;
                    r_drop  <= 1'b1;
`endif
                end else begin
                    r_cnt  <= w_cnt_inc;
                    r_fill <= w_fill_next;
                end
            end
        end
    end

    block_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_block_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_data  (w_push_entry),
        .pop        (out_ready),
        .head       (w_head),
        .head_valid (out_valid),
        .full       (w_fifo_full),
        .count      (fifo_count)
    );

    assign out_block   = w_head.data;
    assign out_encrypt = w_head.encrypt;

endmodule

`default_nettype wire

// File: tb/tb_rx_block_packer.sv
// ============================================================================
//  tb_rx_block_packer
//  Scoreboard bench: a byte-level message model predicts blocks, a negedge
//  monitor pops and compares them as the DUT hands them over.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_block_packer;
    import aes_pkg::*;

    localparam int FIFO_DEPTH = 2;
    localparam int MSB_FIRST  = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = 8'd0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         in_encrypt = 1'b0;
    logic [127:0] out_block;
    logic         out_encrypt;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic         drop_pulse;

    int checks = 0;
    int errors = 0;
    int exp_drops = 0;
    int seen_drops = 0;
    bit rand_ready = 1'b0;

    logic [7:0]  msg_q[$];
    logic        msg_mode;
    blk_entry_t  exp_q[$];

    rx_block_packer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MSB_FIRST  (MSB_FIRST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .in_encrypt  (in_encrypt),
        .out_block   (out_block),
        .out_encrypt (out_encrypt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .drop_pulse  (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: a message is a byte list; 16 bytes make a block, a short
    // message ending in 'last' is padded (PKCS#7) or dropped.
    task automatic emit_block();
        block_t v = '0;
        for (int i = 0; i < 16; i++) begin
            if (MSB_FIRST != 0) v = {v[119:0], msg_q[i]};
            else                v[8*i +: 8] = msg_q[i];
        end
        exp_q.push_back('{data: v, encrypt: msg_mode});
        msg_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] d, input logic last, input logic enc);
        if (msg_q.size() == 0) msg_mode = enc;
        msg_q.push_back(d);
        if (msg_q.size() == 16) emit_block();
        else if (last) begin
`ifdef RX_PKCS7_PAD_EN
            int k;
            k = 16 - msg_q.size();
            repeat (k) msg_q.push_back(8'(k));
            emit_block();
`else
            exp_drops++;
            msg_q.delete();
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic enc);
        int waited = 0;
        in_data = d; in_valid = 1'b1; in_last = last; in_encrypt = enc;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            chk("send_timeout", 128'(waited), 128'(0));
        end else begin
            model_byte(d, last, enc);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", 128'(n < 300), 128'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        msg_q.delete();
        exp_q.delete();
        #1;
        chk("reset_in_ready_low", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_block", out_block, 128'(0));
        chk("reset_out_encrypt", 128'(out_encrypt), 128'(0));
        chk("reset_fifo_count", 128'(fifo_count), 128'(0));
        chk("reset_drop_pulse", 128'(drop_pulse), 128'(0));
        chk("reset_in_ready_high", 128'(in_ready), 128'(1));
    endtask

    // Scoreboard side: compare whenever a block is handed over at the next edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("count_vs_valid", 128'(fifo_count != 0), 128'(out_valid));
            if (drop_pulse) seen_drops++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_block", out_block, 128'(0));
                end else begin
                    blk_entry_t e;
                    e = exp_q.pop_front();
                    chk("block_data", out_block, e.data);
                    chk("block_mode", 128'(out_encrypt), 128'(e.encrypt));
                end
            end
        end
    end

    initial begin
        int lowc;
        @(posedge clk);
        #1;
        do_reset();

        // Straight block with latency and content check.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b1);
        chk("first_valid_latency", 128'(out_valid), 128'(1));
        chk("first_block", out_block, 128'h000102030405060708090a0b0c0d0e0f);
        chk("first_mode", 128'(out_encrypt), 128'(1));
        drain();

        // Backpressure: fill FIFO, stall on the 48th byte, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send_byte(8'($urandom), 1'b0, 1'(i / 16));
        chk("bp_fifo_count_full", 128'(fifo_count), 128'(2));
        for (int i = 0; i < 15; i++) send_byte(8'(8'h40 + i), 1'b0, 1'b1);
        chk("bp_in_ready_low", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        send_byte(8'h4f, 1'b0, 1'b1);
        drain();

        // Short message terminated by in_last.
        for (int i = 0; i < 5; i++) send_byte(8'haa, i == 4, 1'b1);
`ifdef RX_PKCS7_PAD_EN
        chk("short_drop_pulse", 128'(drop_pulse), 128'(0));
`else
        chk("short_drop_pulse", 128'(drop_pulse), 128'(1));
`endif
        lowc = 0;
        while (!in_ready && lowc < 40) begin
            tick();
            lowc++;
        end
`ifdef RX_PKCS7_PAD_EN
        chk("pad_ready_low_cycles", 128'(lowc), 128'(11));
        chk("pad_block_valid", 128'(out_valid), 128'(1));
        chk("pad_block_value", out_block, {{5{8'haa}}, {11{8'h0b}}});
`else
        chk("pad_ready_low_cycles", 128'(lowc), 128'(0));
`endif
        drain();

        // 64 bytes back to back with the consumer always ready.
        for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        drain();

        // Reset mid-block, then a clean block.
        for (int i = 0; i < 7; i++) send_byte(8'hee, 1'b0, 1'b1);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b0, 1'b0);
        chk("post_reset_block", out_block, 128'h808182838485868788898a8b8c8d8e8f);
        drain();

        // Mode toggles mid-block; byte 0 decides.
        for (int i = 0; i < 16; i++) send_byte(8'(i * 3), 1'b0, 1'(i >= 8));
        chk("mode_from_byte0", 128'(out_encrypt), 128'(0));
        drain();

        // Randomized traffic with random gaps, last markers and backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            send_byte(8'($urandom), $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        chk("drop_count", 128'(seen_drops), 128'(exp_drops));
        chk("final_fifo_count", 128'(fifo_count), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
